// File: rtl/crc16_frame_sched.sv
// crc16_frame_sched: two-source, frame-granular round-robin scheduler that
// shares one word-parallel CRC-16/CCITT engine. Each granted frame is forwarded
// word by word through a single output register, and its CRC follows as the
// final word, flagged with m_last.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no frame owns the datapath; pick a source and preset the CRC
//   PASS   | forward the granted source's words and fold each one into the CRC
//   APPEND | emit the finished CRC as the frame's last word

module crc16_frame_sched #(
    parameter int          MAX_WORDS = 256,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [15:0] s0_data,
    input  logic        s0_last,

    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [15:0] s1_data,
    input  logic        s1_last,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_last,
    output logic        m_src,

    output logic        trunc,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PASS   = 2'd1,
        ST_APPEND = 2'd2
    } state_t;

    // Count value reached by the word that fills a frame to MAX_WORDS.
    localparam logic [15:0] LAST_IDX = 16'(MAX_WORDS - 1);

    state_t      state;
    state_t      state_next;
    logic        grant;
    logic        grant_next;
    logic        rr;
    logic        rr_next;
    logic [15:0] crc;
    logic [15:0] word_cnt;

    logic        slot_free;
    logic        sel_valid;
    logic [15:0] sel_data;
    logic        sel_last;
    logic        start;
    logic        accept;
    logic        emit_crc;
    logic        hit_max;

    // One data word folded into the CRC: (crc ^ w) shifted through 16 zero
    // bits, i.e. multiplied by x^16 and reduced modulo 0x1021, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] v;
        v = c ^ w;
        for (int i = 0; i < 16; i++) begin
            v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
        end
        return v;
    endfunction

    assign slot_free = !m_valid || m_ready;
    assign sel_valid = grant ? s1_valid : s0_valid;
    assign sel_data  = grant ? s1_data  : s0_data;
    assign sel_last  = grant ? s1_last  : s0_last;

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= 1'b0;
            rr    <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            rr    <= rr_next;
        end
    end

    // Next-state logic, handshake back to the sources and datapath strobes.
    always_comb begin
        state_next = state;
        grant_next = grant;
        rr_next    = rr;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        start      = 1'b0;
        accept     = 1'b0;
        emit_crc   = 1'b0;
        hit_max    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    start      = 1'b1;
                    grant_next = (s0_valid && s1_valid) ? rr : s1_valid;
                    rr_next    = !grant_next;
                    state_next = ST_PASS;
                end
            end
            ST_PASS: begin
                s0_ready = !grant && slot_free;
                s1_ready = grant && slot_free;
                accept   = sel_valid && slot_free;
                if (accept) begin
                    if (sel_last) begin
                        state_next = ST_APPEND;
                    end else if (word_cnt == LAST_IDX) begin
                        // A word carrying last exactly at the limit is a clean
                        // end of frame, so only the non-last case truncates.
                        hit_max    = 1'b1;
                        state_next = ST_APPEND;
                    end
                end
            end
            ST_APPEND: begin
                if (slot_free) begin
                    emit_crc   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // CRC accumulator, per-frame word count and truncation pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc      <= CRC_INIT;
            word_cnt <= 16'd0;
            trunc    <= 1'b0;
        end else begin
            trunc <= hit_max;
            if (start) begin
                crc      <= CRC_INIT;
                word_cnt <= 16'd0;
            end else if (accept) begin
                crc      <= crc_step(crc, sel_data);
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

    // Output register: loads only into a free slot, otherwise holds its word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 16'd0;
            m_last  <= 1'b0;
            m_src   <= 1'b0;
        end else if (slot_free) begin
            m_valid <= accept || emit_crc;
            if (accept) begin
                m_data <= sel_data;
                m_last <= 1'b0;
                m_src  <= grant;
            end else if (emit_crc) begin
                m_data <= crc;
                m_last <= 1'b1;
                m_src  <= grant;
            end
        end
    end

    // Completed-frame counter, advanced when the CRC word is taken downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (m_valid && m_ready && m_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_crc16_frame_sched.sv
// Directed bench for crc16_frame_sched: one default instance plus a
// MAX_WORDS=4 instance for the truncation scenario.

module tb_crc16_frame_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
    logic [15:0] s0_data = 16'd0, s1_data = 16'd0;
    logic        s0_ready, s1_ready;
    logic        m_valid, m_last, m_src, trunc;
    logic        m_ready = 1'b1;
    logic [15:0] m_data, frame_cnt;

    logic        t_s0_valid = 1'b0, t_s0_last = 1'b0;
    logic [15:0] t_s0_data = 16'd0;
    logic        t_s0_ready, t_s1_ready;
    logic        t_m_valid, t_m_last, t_m_src, t_trunc;
    logic        t_m_ready = 1'b1;
    logic [15:0] t_m_data, t_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] q_a[$];
    logic [17:0] q_b[$];
    logic [17:0] exp_q[$];
    logic [17:0] held = 18'd0;
    logic        stalled_prev = 1'b0;
    int          stall_err = 0;
    int          stall_seen = 0;
    int          trunc_b = 0;
    bit          bp_done = 0;

    always #5 clk = ~clk;

    crc16_frame_sched dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_src(m_src), .trunc(trunc), .frame_cnt(frame_cnt)
    );

    crc16_frame_sched #(.MAX_WORDS(4)) dut_t (
        .clk(clk), .rst(rst),
        .s0_valid(t_s0_valid), .s0_ready(t_s0_ready), .s0_data(t_s0_data), .s0_last(t_s0_last),
        .s1_valid(1'b0), .s1_ready(t_s1_ready), .s1_data(16'd0), .s1_last(1'b0),
        .m_valid(t_m_valid), .m_ready(t_m_ready), .m_data(t_m_data), .m_last(t_m_last),
        .m_src(t_m_src), .trunc(t_trunc), .frame_cnt(t_frame_cnt)
    );

    // Capture accepted output words and watch for words changing while stalled.
    always @(posedge clk) begin
        if (rst) begin
            stalled_prev <= 1'b0;
        end else begin
            if (m_valid && m_ready) q_a.push_back({m_src, m_last, m_data});
            if (t_m_valid && t_m_ready) q_b.push_back({t_m_src, t_m_last, t_m_data});
            if (stalled_prev && ({m_valid, m_src, m_last, m_data} !== {1'b1, held}))
                stall_err <= stall_err + 1;
            if (m_valid && !m_ready) stall_seen <= stall_seen + 1;
            stalled_prev <= m_valid && !m_ready;
            held         <= {m_src, m_last, m_data};
            if (t_trunc) trunc_b <= trunc_b + 1;
        end
    end

    // Bit-serial MSB-first CRC-16/CCITT reference, preset 0xFFFF.
    function automatic logic [15:0] crc_ref(input logic [15:0] w[$]);
        logic [15:0] c;
        logic [15:0] cur;
        logic        fb;
        c = 16'hFFFF;
        foreach (w[k]) begin
            cur = w[k];
            for (int b = 15; b >= 0; b--) begin
                fb = c[15] ^ cur[b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic void push_exp(input logic s, input logic [15:0] w[$]);
        foreach (w[k]) exp_q.push_back({s, 1'b0, w[k]});
        exp_q.push_back({s, 1'b1, crc_ref(w)});
    endfunction

    task automatic send_word(input int s, input logic [15:0] d, input logic l, output bit ok);
        bit got;
        ok = 0;
        @(negedge clk);
        case (s)
            0: begin s0_valid = 1'b1; s0_data = d; s0_last = l; end
            1: begin s1_valid = 1'b1; s1_data = d; s1_last = l; end
            default: begin t_s0_valid = 1'b1; t_s0_data = d; t_s0_last = l; end
        endcase
        for (int c = 0; c < 400; c++) begin
            #4;
            got = (s == 0) ? s0_ready : (s == 1) ? s1_ready : t_s0_ready;
            @(posedge clk);
            if (got) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        #1;
        case (s)
            0: s0_valid = 1'b0;
            1: s1_valid = 1'b0;
            default: t_s0_valid = 1'b0;
        endcase
    endtask

    task automatic send_frame(input int s, input logic [15:0] w[$], output bit ok);
        bit okw;
        ok = 1;
        foreach (w[k]) begin
            send_word(s, w[k], (k == w.size() - 1), okw);
            if (!okw) ok = 0;
        end
    endtask

    task automatic wait_q(input int which, input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (((which == 0) ? q_a.size() : q_b.size()) >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_checks++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
        n_checks++; if ({m_last, m_src, trunc} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {m_last, m_src, trunc}); end
        n_checks++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {s0_ready, s1_ready}); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_single(input int s, input logic [15:0] w, input logic [15:0] crc_exp,
                               input logic [15:0] cnt_exp);
        logic [15:0] f[$];
        bit ok;
        bit okq;
        q_a.delete();
        f = {w};
        send_frame(s, f, ok);
        wait_q(0, 2, okq);
        repeat (2) @(negedge clk);
        n_checks++; if (!(ok && okq)) begin n_fail++; $display("FAIL single_timeout: got ok=%b/%b expected 1/1", ok, okq); end
        n_checks++; if (q_a.size() !== 2) begin n_fail++; $display("FAIL single_count: got %0d expected 2", q_a.size()); end
        if (q_a.size() >= 2) begin
            n_checks++; if (q_a[0] !== {s[0], 1'b0, w}) begin n_fail++; $display("FAIL single_data: got %h expected %h", q_a[0], {s[0], 1'b0, w}); end
            n_checks++; if (q_a[1] !== {s[0], 1'b1, crc_exp}) begin n_fail++; $display("FAIL single_crc: got %h expected %h", q_a[1], {s[0], 1'b1, crc_exp}); end
        end
        n_checks++; if (frame_cnt !== cnt_exp) begin n_fail++; $display("FAIL single_frame_cnt: got %0d expected %0d", frame_cnt, cnt_exp); end
    endtask

    task automatic test_round_robin();
        logic [15:0] a0[$], a1[$], b0[$], b1[$];
        bit ok0, ok1, okq;
        do_reset();
        a0 = {16'h1234, 16'h5678, 16'h9ABC};
        a1 = {16'hDEAD, 16'hBEEF, 16'h0000};
        b0 = {16'h0001, 16'h0002, 16'h0003};
        b1 = {16'hFFFF, 16'h8000, 16'h00FF};
        exp_q.delete();
        push_exp(1'b0, a0); push_exp(1'b1, b0); push_exp(1'b0, a1); push_exp(1'b1, b1);
        fork
            begin bit k; send_frame(0, a0, ok0); send_frame(0, a1, k); ok0 &= k; end
            begin bit k; send_frame(1, b0, ok1); send_frame(1, b1, k); ok1 &= k; end
        join
        wait_q(0, 16, okq);
        repeat (2) @(negedge clk);
        n_checks++; if (!(ok0 && ok1 && okq)) begin n_fail++; $display("FAIL rr_timeout: got %b%b%b expected 111", ok0, ok1, okq); end
        n_checks++; if (q_a.size() !== 16) begin n_fail++; $display("FAIL rr_count: got %0d expected 16", q_a.size()); end
        for (int i = 0; i < 16 && i < q_a.size(); i++) begin
            n_checks++; if (q_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_word%0d: got %h expected %h", i, q_a[i], exp_q[i]); end
        end
        n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL rr_frame_cnt: got %0d expected 4", frame_cnt); end
    endtask

    task automatic test_backpressure();
        logic [15:0] f[$];
        logic [17:0] ref_run[$];
        bit ok, okq;
        int se0, ss0;
        f = {16'h0102, 16'h0304, 16'hA5A5, 16'h5A5A, 16'h8001,
             16'h7FFE, 16'h00FF, 16'hFF00, 16'h1111, 16'hCAFE};
        exp_q.delete();
        push_exp(1'b1, f);
        m_ready = 1'b1;
        q_a.delete();
        send_frame(1, f, ok);
        wait_q(0, 11, okq);
        n_checks++; if (!(ok && okq)) begin n_fail++; $display("FAIL bp_full_timeout: got %b%b expected 11", ok, okq); end
        for (int i = 0; i < 11 && i < q_a.size(); i++) begin
            n_checks++; if (q_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_full_word%0d: got %h expected %h", i, q_a[i], exp_q[i]); end
        end
        ref_run = q_a;
        repeat (2) @(negedge clk);
        q_a.delete();
        se0 = stall_err;
        ss0 = stall_seen;
        bp_done = 0;
        fork
            begin send_frame(1, f, ok); wait_q(0, 11, okq); bp_done = 1; end
            begin
                while (!bp_done) begin
                    @(negedge clk);
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (!(ok && okq)) begin n_fail++; $display("FAIL bp_rand_timeout: got %b%b expected 11", ok, okq); end
        n_checks++; if (q_a.size() !== 11) begin n_fail++; $display("FAIL bp_rand_count: got %0d expected 11", q_a.size()); end
        for (int i = 0; i < 11 && i < q_a.size() && i < ref_run.size(); i++) begin
            n_checks++; if (q_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_rand_word%0d: got %h expected %h (ready=1 run %h)", i, q_a[i], exp_q[i], ref_run[i]); end
        end
        n_checks++; if (stall_err !== se0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_err - se0); end
        n_checks++; if (!(stall_seen > ss0)) begin n_fail++; $display("FAIL bp_stalls_seen: got %0d stall cycles expected >0", stall_seen - ss0); end
    endtask

    task automatic test_trunc();
        logic [15:0] f[$], p1[$], p2[$];
        bit ok, okq;
        f  = {16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB};
        p1 = {16'h0011, 16'h2233, 16'h4455, 16'h6677};
        p2 = {16'h8899, 16'hAABB};
        exp_q.delete();
        push_exp(1'b0, p1);
        push_exp(1'b0, p2);
        q_b.delete();
        send_frame(2, f, ok);
        wait_q(1, 8, okq);
        repeat (2) @(negedge clk);
        n_checks++; if (!(ok && okq)) begin n_fail++; $display("FAIL trunc_timeout: got %b%b expected 11", ok, okq); end
        n_checks++; if (q_b.size() !== 8) begin n_fail++; $display("FAIL trunc_count: got %0d expected 8", q_b.size()); end
        for (int i = 0; i < 8 && i < q_b.size(); i++) begin
            n_checks++; if (q_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL trunc_word%0d: got %h expected %h", i, q_b[i], exp_q[i]); end
        end
        n_checks++; if (trunc_b !== 1) begin n_fail++; $display("FAIL trunc_pulses: got %0d expected 1", trunc_b); end
        n_checks++; if (t_frame_cnt !== 16'd2) begin n_fail++; $display("FAIL trunc_frame_cnt: got %0d expected 2", t_frame_cnt); end
    endtask

    task automatic test_rst_mid_frame();
        logic [15:0] f[$];
        bit ok0, ok1, ok, okq;
        m_ready = 1'b1;
        send_word(0, 16'h1357, 1'b0, ok0);
        send_word(0, 16'h2468, 1'b0, ok1);
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", m_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if ({m_valid, m_last, m_src, trunc, s0_ready, s1_ready} !== 6'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000000", {m_valid, m_last, m_src, trunc, s0_ready, s1_ready}); end
        n_checks++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 0000", m_data); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_frame_cnt: got %0d expected 0", frame_cnt); end
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        f = {16'hFFFE};
        send_frame(0, f, ok);
        wait_q(0, 2, okq);
        repeat (4) @(negedge clk);
        n_checks++; if (!(ok0 && ok1 && ok && okq)) begin n_fail++; $display("FAIL rst_timeout: got %b%b%b%b expected 1111", ok0, ok1, ok, okq); end
        n_checks++; if (q_a.size() !== 2) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 2", q_a.size()); end
        if (q_a.size() >= 2) begin
            n_checks++; if (q_a[0] !== {2'b00, 16'hFFFE}) begin n_fail++; $display("FAIL rst_after_data: got %h expected 0fffe", q_a[0]); end
            n_checks++; if (q_a[1] !== {2'b01, 16'h1021}) begin n_fail++; $display("FAIL rst_after_crc: got %h expected 11021", q_a[1]); end
        end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_after_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_single(0, 16'hFFFF, 16'h0000, 16'd1);
        test_single(1, 16'hFFFE, 16'h1021, 16'd2);
        test_round_robin();
        test_backpressure();
        test_trunc();
        test_rst_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
